// File: rtl/cla_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit carry-lookahead slice per clock,
// least-significant slice first, with valid/ready handshakes on both sides.

module cla_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             cmsb,
    output logic             co
);
    logic [CHUNK-1:0] g, p;
    logic [CHUNK:0]   c;

    // Each carry is a flat sum of products of g/p terms and ci; no bit-to-bit ripple.
    function automatic logic [CHUNK:0] lookahead(input logic [CHUNK-1:0] gv,
                                                 input logic [CHUNK-1:0] pv,
                                                 input logic             civ);
        logic [CHUNK:0] cv;
        logic           acc, pp;
        cv    = '0;
        cv[0] = civ;
        for (int i = 1; i <= CHUNK; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (gv[j] & pp);
                pp  = pp & pv[j];
            end
            cv[i] = acc | (pp & civ);
        end
        return cv;
    endfunction

    assign g    = a & b;
    assign p    = a ^ b;
    assign c    = lookahead(g, p, ci);
    assign s    = p ^ c[CHUNK-1:0];
    assign cmsb = c[CHUNK-1];
    assign co   = c[CHUNK];
endmodule

module cla_serial_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("cla_serial_addsub: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q, b_q;
    logic             sub_q, carry_q;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] a_sl, b_sl, s_sl;
    logic             cmsb_sl, co_sl, last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (idx == IW'(NCH - 1));
    assign a_sl      = a_q[int'(idx)*CHUNK +: CHUNK];
    assign b_sl      = b_q[int'(idx)*CHUNK +: CHUNK];

    cla_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .ci   (carry_q),
        .s    (s_sl),
        .cmsb (cmsb_sl),
        .co   (co_sl)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // Subtract runs as a + ~b + ~borrow_in; cout is inverted back at the end.
                    a_q     <= a;
                    b_q     <= sub ? ~b : b;
                    sub_q   <= sub;
                    carry_q <= cin ^ sub;
                    idx     <= '0;
                end
                RUN: begin
                    sum[int'(idx)*CHUNK +: CHUNK] <= s_sl;
                    carry_q <= co_sl;
                    idx     <= idx + 1'b1;
                    if (last) begin
                        cout <= co_sl ^ sub_q;
                        ovf  <= cmsb_sl ^ co_sl;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_serial_addsub.sv
// Four configurations run in parallel; directed cases then random traffic per DUT,
// checked by a scoreboard fed at acceptance and drained by an output monitor.

module tb_cla_serial_addsub;
    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
        localparam int W    = (gi == 3) ? 16 : 32;
        localparam int C    = (gi == 0) ? 8 : (gi == 1) ? 1 : (gi == 2) ? 32 : 4;
        localparam int NCH  = W / C;
        localparam int NOPS = (C == 1) ? 1500 : 2000;
        localparam logic [31:0] M = 32'((64'd1 << W) - 64'd1);
        localparam logic [31:0] H = 32'(64'd1 << (W - 1));

        logic         rst = 1'b1;
        logic         in_valid = 1'b0, sub = 1'b0, cin = 1'b0, out_ready = 1'b0;
        logic [W-1:0] a = '0, b = '0;
        logic         in_ready, out_valid, cout, ovf;
        logic [W-1:0] sum;
        logic         force_mode = 1'b1, force_val = 1'b0, done = 1'b0;
        exp_t         q[$];
        exp_t         mon_e;

        cla_serial_addsub #(.WIDTH(W), .CHUNK(C)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .b(b), .sub(sub), .cin(cin),
            .out_valid(out_valid), .out_ready(out_ready),
            .sum(sum), .cout(cout), .ovf(ovf)
        );

        function automatic logic [31:0] x32(input logic [W-1:0] v);
            logic [31:0] r;
            r        = '0;
            r[W-1:0] = v;
            return r;
        endfunction

        // Reference: plain integer arithmetic on unsigned and signed interpretations.
        function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                       input logic sb, input logic ci);
            longint ua, ub, cc, r, sa, sbv, sr, lim;
            exp_t   e;
            ua  = {32'd0, av};
            ub  = {32'd0, bv};
            cc  = {63'd0, ci};
            lim = longint'(1) << (W - 1);
            sa  = (ua >= lim) ? ua - 2 * lim : ua;
            sbv = (ub >= lim) ? ub - 2 * lim : ub;
            if (sb) begin
                r    = ua - ub - cc;
                sr   = sa - sbv - cc;
                e.co = (r < 0);
            end else begin
                r    = ua + ub + cc;
                sr   = sa + sbv + cc;
                e.co = (r >= 2 * lim);
            end
            e.s  = 32'(r & (2 * lim - 1));
            e.ov = (sr >= lim) || (sr < -lim);
            return e;
        endfunction

        function automatic logic [31:0] pick();
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0:       return 32'd0;
                    1:       return M;
                    2:       return H;
                    3:       return H - 1;
                    default: return 32'd1;
                endcase
            end
            return $urandom & M;
        endfunction

        always begin
            @(posedge clk);
            #1;
            out_ready = force_mode ? force_val : ($urandom_range(0, 3) != 0);
        end

        always @(negedge clk)
            if (!rst && in_valid && in_ready)
                q.push_back(model(x32(a), x32(b), sub, cin));

        always @(negedge clk) begin
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL c%0d_unexpected_output actual=valid required=none", gi);
                end else begin
                    mon_e = q.pop_front();
                    chk($sformatf("c%0d_sb_sum", gi), x32(sum), mon_e.s);
                    chk($sformatf("c%0d_sb_cout", gi), {31'd0, cout}, {31'd0, mon_e.co});
                    chk($sformatf("c%0d_sb_ovf", gi), {31'd0, ovf}, {31'd0, mon_e.ov});
                end
            end
        end

        // Called just after a rising edge; returns just after the accepting edge.
        task automatic send(input logic [31:0] av, input logic [31:0] bv,
                            input logic sb, input logic ci);
            logic acc;
            in_valid = 1'b1;
            a = av[W-1:0];
            b = bv[W-1:0];
            sub = sb;
            cin = ci;
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL c%0d_accept_timeout actual=0 required=1", gi);
            end
            in_valid = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
            sub = 1'($urandom);
            cin = 1'($urandom);
        endtask

        task automatic release_result(input string nm);
            force_val = 1'b1;
            for (int t = 0; t < 10 && out_valid; t++) @(negedge clk);
            chk({nm, "_released"}, {31'd0, out_valid}, 32'd0);
            force_val = 1'b0;
            @(posedge clk);
            #1;
        endtask

        task automatic dir(input string nm, input logic [31:0] av, input logic [31:0] bv,
                           input logic sb, input logic ci,
                           input logic [31:0] es, input logic eco, input logic eov);
            force_mode = 1'b1;
            force_val  = 1'b0;
            send(av, bv, sb, ci);
            for (int k = 0; k < NCH; k++) begin
                @(negedge clk);
                chk({nm, "_busy"}, {30'd0, out_valid, in_ready}, 32'd0);
            end
            @(negedge clk);
            chk({nm, "_latency"}, {31'd0, out_valid}, 32'd1);
            for (int k = 0; k < 5; k++) begin
                chk({nm, "_sum"}, x32(sum), es);
                chk({nm, "_flags"}, {29'd0, in_ready, cout, ovf}, {29'd0, 1'b0, eco, eov});
                @(negedge clk);
            end
            release_result(nm);
        endtask

        initial begin
            string p;
            p = $sformatf("c%0d", gi);
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk({p, "_reset"}, {27'd0, out_valid, in_ready, cout, ovf, 1'b0}, 32'b01000);
            chk({p, "_reset_sum"}, x32(sum), 32'd0);
            @(posedge clk);
            #1;

            dir({p, "_ones_p1"}, M, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            dir({p, "_max_p1"}, H - 1, 32'd1, 1'b0, 1'b0, H, 1'b0, 1'b1);
            dir({p, "_cin"}, 32'd0, 32'd0, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0);
            dir({p, "_5m7"}, 32'd5, 32'd7, 1'b1, 1'b0, M - 1, 1'b1, 1'b0);
            dir({p, "_minm1"}, H, 32'd1, 1'b1, 1'b0, H - 1, 1'b0, 1'b1);
            dir({p, "_10m3b"}, 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b0, 1'b0);

            // in_valid held through the output handshake: accepted one cycle later.
            force_val = 1'b0;
            send(32'd100, 32'd23, 1'b0, 1'b0);
            in_valid = 1'b1;
            a = W'(32'd9);
            b = W'(32'd4);
            sub = 1'b1;
            cin = 1'b0;
            for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
            chk({p, "_kv_first"}, x32(sum), 32'd123);
            force_val = 1'b1;
            @(posedge clk);
            #1;
            @(negedge clk);
            @(negedge clk);
            chk({p, "_kv_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
            force_val = 1'b0;
            @(negedge clk);
            chk({p, "_kv_taken"}, {30'd0, out_valid, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
            for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
            chk({p, "_kv_second"}, x32(sum), 32'd5);
            release_result({p, "_kv"});

            // Reset during the second RUN cycle abandons the operation.
            send(32'd1234, 32'd77, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            rst = 1'b1;
            q.delete();
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk({p, "_midrst"}, {27'd0, out_valid, in_ready, cout, ovf, 1'b0}, 32'b01000);
            chk({p, "_midrst_sum"}, x32(sum), 32'd0);
            @(posedge clk);
            #1;
            dir({p, "_after_rst"}, 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

            force_mode = 1'b0;
            for (int n = 0; n < NOPS; n++) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
                send(pick(), pick(), 1'($urandom), 1'($urandom));
            end
            for (int t = 0; t < 500 && q.size() != 0; t++) @(negedge clk);
            chk({p, "_drain"}, q.size(), 32'd0);
            done = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (t < 80000 && !(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done)) begin
            @(posedge clk);
            t++;
        end
        if (t >= 80000) begin
            checks++;
            failures++;
            $display("FAIL global_timeout actual=%0d required=<80000 cycles", t);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
